// File: rtl/decode_issue.sv
// Decode/issue stage: register file, RAW scoreboard with last-slot bypass,
// and fixed-latency writeback of the execute stage's result.
module decode_issue #(
  parameter int unsigned WB_LAT      = 3,
  parameter logic [2:0]  STORE_OPSEL = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        enable_ex,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] imm,
  output logic [6:0]  control_out,
  input  logic [31:0] aluout,
  input  logic        carry,
  output logic        carry_flag,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] r_regs    [32];
  logic        r_pend_v  [1:WB_LAT];
  logic [4:0]  r_pend_rd [1:WB_LAT];

  logic [6:0]  w_ctrl;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_is_store;
  logic        w_chk_rs2;
  logic        w_stall;
  logic        w_accept;
  logic        w_wb;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_rf1;
  logic [31:0] w_rf2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_imm;

  assign w_ctrl     = instr[31:25];
  assign w_rd       = instr[24:20];
  assign w_rs1      = instr[19:15];
  assign w_rs2      = instr[14:10];
  assign w_imm      = {{17{instr[14]}}, instr[14:0]};
  assign w_is_store = (w_ctrl[5:3] == STORE_OPSEL);
  assign w_chk_rs2  = (w_rs2 != '0) && (!w_ctrl[6] || w_is_store);
  assign w_wb       = r_pend_v[WB_LAT];
  assign w_wb_rd    = r_pend_rd[WB_LAT];

  // The last slot is excluded: its result is forwarded from aluout instead.
  always_comb begin
    w_stall = 1'b0;
    for (int unsigned k = 1; k < WB_LAT; k++) begin
      if (r_pend_v[k]) begin
        if ((w_rs1 != '0) && (r_pend_rd[k] == w_rs1)) w_stall = 1'b1;
        if (w_chk_rs2 && (r_pend_rd[k] == w_rs2))     w_stall = 1'b1;
      end
    end
  end

  assign instr_ready = ~reset & ~w_stall;
  assign w_accept    = instr_valid & instr_ready;

  always_comb begin
    w_rf1 = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    w_rf2 = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
    w_op1 = (w_wb && (w_rs1 != '0) && (w_wb_rd == w_rs1)) ? aluout : w_rf1;
    w_op2 = (w_wb && (w_rs2 != '0) && (w_wb_rd == w_rs2)) ? aluout : w_rf2;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_ex   <= 1'b0;
      src1        <= '0;
      src2        <= '0;
      imm         <= '0;
      control_out <= '0;
      carry_flag  <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
      for (int unsigned k = 1; k <= WB_LAT; k++) begin
        r_pend_v[k]  <= 1'b0;
        r_pend_rd[k] <= '0;
      end
    end else begin
      enable_ex <= w_accept;
      if (w_accept) begin
        src1        <= w_op1;
        src2        <= w_op2;
        imm         <= w_imm;
        control_out <= w_ctrl;
      end
      r_pend_v[1]  <= w_accept && !w_is_store && (w_rd != '0);
      r_pend_rd[1] <= w_rd;
      for (int unsigned k = 2; k <= WB_LAT; k++) begin
        r_pend_v[k]  <= r_pend_v[k-1];
        r_pend_rd[k] <= r_pend_rd[k-1];
      end
      if (w_wb) begin
        r_regs[w_wb_rd] <= aluout;
        carry_flag      <= carry;
      end
    end
  end

endmodule
